m216a_mmd_div: RTL and testbench

M216A_MMD_DIV -- requirements
Module: m216a_mmd_div

---
 rtl/m216a_mmd_div.sv | 120 ++++++++++++
 tb/tb_m216a_mmd_div.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/m216a_mmd_div.sv
// Multi-modulus clock divider: each period runs for a ratio taken from the upstream
// modulator, producing a divided clock plus request and period-end strobes.
module m216a_mmd_div #(
    parameter int N_MIN = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] div_in,
    input  logic       clr_err,
    output logic       div_req,
    output logic       div_pulse,
    output logic       div_clk,
    output logic [3:0] ratio_q,
    output logic       range_err
);

    // state | meaning
    // IDLE  | stopped, outputs low, waiting for en
    // RUN   | counting down the current divide period
    localparam logic       IDLE = 1'b0;
    localparam logic       RUN  = 1'b1;
    localparam logic [3:0] N_MIN_C = 4'(N_MIN);

    logic       state_q,     state_d;
    logic [3:0] cnt_q,       cnt_d;
    logic [3:0] ratio_d;
    logic       range_err_q, range_err_d;
    logic       div_clk_q,   div_clk_d;
    logic       div_req_q,   div_req_d;
    logic       div_pulse_q, div_pulse_d;

    logic       under_min;
    logic [3:0] eff_n;
    logic       load;
    logic [4:0] half_up;

    assign under_min = (div_in < N_MIN_C);
    assign eff_n     = under_min ? N_MIN_C : div_in;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ratio_d     = ratio_q;
        div_req_d   = 1'b0;
        div_pulse_d = 1'b0;
        load        = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (en) begin
                    load = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else if (en) begin
                    load        = 1'b1;
                    div_pulse_d = 1'b1;
                end else begin
                    // Period finished with en low: close it out without consuming a ratio.
                    state_d     = IDLE;
                    cnt_d       = 4'd0;
                    div_pulse_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        if (load) begin
            state_d   = RUN;
            ratio_d   = eff_n;
            cnt_d     = eff_n - 4'd1;
            div_req_d = 1'b1;
        end

        // High while the remaining count covers the first floor(N/2) cycles.
        half_up   = (5'(ratio_d) + 5'd1) >> 1;
        div_clk_d = (state_d == RUN) && (5'(cnt_d) >= half_up);

        if (load && under_min) begin
            range_err_d = 1'b1;
        end else if (clr_err) begin
            range_err_d = 1'b0;
        end else begin
            range_err_d = range_err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ratio_q     <= 4'd0;
            range_err_q <= 1'b0;
            div_clk_q   <= 1'b0;
            div_req_q   <= 1'b0;
            div_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ratio_q     <= ratio_d;
            range_err_q <= range_err_d;
            div_clk_q   <= div_clk_d;
            div_req_q   <= div_req_d;
            div_pulse_q <= div_pulse_d;
        end
    end

    assign div_req   = div_req_q;
    assign div_pulse = div_pulse_q;
    assign div_clk   = div_clk_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_m216a_mmd_div.sv
// Directed bench for m216a_mmd_div: period lengths, duty, strobes, clamping,
// sticky error, early-stop and asynchronous reset behaviour.
module tb_m216a_mmd_div;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] div_in;
    logic       clr_err;
    logic       div_req;
    logic       div_pulse;
    logic       div_clk;
    logic [3:0] ratio_q;
    logic       range_err;

    int checks   = 0;
    int failures = 0;

    m216a_mmd_div #(.N_MIN(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .div_in    (div_in),
        .clr_err   (clr_err),
        .div_req   (div_req),
        .div_pulse (div_pulse),
        .div_clk   (div_clk),
        .ratio_q   (ratio_q),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"},   8'(div_req),   8'd0);
        check({tag, "_pulse"}, 8'(div_pulse), 8'd0);
        check({tag, "_dclk"},  8'(div_clk),   8'd0);
        check({tag, "_ratio"}, 8'(ratio_q),   8'd0);
        check({tag, "_err"},   8'(range_err), 8'd0);
    endtask

    // One full period starting at a load edge; din is perturbed after the load
    // to show it is only sampled on load edges.
    task automatic run_period(input logic [3:0] din, input logic [3:0] n, input logic first);
        div_in = din;
        en     = 1'b1;
        for (int k = 0; k < int'(n); k++) begin
            tick();
            check("req",   8'(div_req),   8'(k == 0));
            check("pulse", 8'(div_pulse), 8'((k == 0) && !first));
            check("dclk",  8'(div_clk),   8'(k < int'(n) / 2));
            check("ratio", 8'(ratio_q),   8'(n));
            if (k == 0) begin
                div_in  = ~din;
                clr_err = 1'b0;
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        div_in  = 4'd0;
        clr_err = 1'b0;
        #2;
        check_all_zero("rst");
        tick();
        tick();
        rst_n = 1'b1;

        tick();
        check("idle_req", 8'(div_req), 8'd0);
        check("idle_ratio", 8'(ratio_q), 8'd0);

        // Constant ratio 5
        run_period(4'd5, 4'd5, 1'b1);
        run_period(4'd5, 4'd5, 1'b0);
        run_period(4'd5, 4'd5, 1'b0);

        // Alternating 12 / 5
        run_period(4'd12, 4'd12, 1'b0);
        run_period(4'd5,  4'd5,  1'b0);
        run_period(4'd12, 4'd12, 1'b0);
        check("err_legal", 8'(range_err), 8'd0);

        // Ratios below minimum clamp to 2 and set the sticky error
        run_period(4'd0, 4'd2, 1'b0);
        check("err_set0", 8'(range_err), 8'd1);
        run_period(4'd1, 4'd2, 1'b0);
        check("err_set1", 8'(range_err), 8'd1);
        clr_err = 1'b1;
        run_period(4'd6, 4'd6, 1'b0);
        check("err_clr", 8'(range_err), 8'd0);
        clr_err = 1'b1;
        run_period(4'd0, 4'd2, 1'b0);
        check("err_set_wins", 8'(range_err), 8'd1);

        // Maximum ratio
        run_period(4'd15, 4'd15, 1'b0);

        // en dropped on cycle 3 of an 8-cycle period
        div_in = 4'd8;
        en     = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("stop_req",   8'(div_req),   8'(k == 0));
            check("stop_pulse", 8'(div_pulse), 8'(k == 0));
            check("stop_dclk",  8'(div_clk),   8'(k < 4));
            if (k == 2) en = 1'b0;
        end
        tick();
        check("stop_end_pulse", 8'(div_pulse), 8'd1);
        check("stop_end_req",   8'(div_req),   8'd0);
        check("stop_end_dclk",  8'(div_clk),   8'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("idle2_req",   8'(div_req),   8'd0);
            check("idle2_pulse", 8'(div_pulse), 8'd0);
            check("idle2_ratio", 8'(ratio_q),   8'd8);
        end

        // Restart from idle, then reset mid-way through an N=12 period
        run_period(4'd7, 4'd7, 1'b1);
        div_in = 4'd12;
        en     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("pre_rst_ratio", 8'(ratio_q), 8'd12);
        end
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        check("post_rst_idle_req", 8'(div_req), 8'd0);
        run_period(4'd5, 4'd5, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
